// File: rtl/cp0_vectored.sv
// Vectored co-processor 0: prioritised maskable interrupts with a per-source vector table.
// Optional IRQ_SYNC_EN adds a 2-flop synchronizer on each ir_in bit before edge detection.
module cp0_vectored #(
    parameter int unsigned IRQ_NUM    = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int unsigned VEC_STRIDE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          oper,
    input  logic [4:0]          addr_r,
    output logic [31:0]         data_r,
    input  logic [4:0]          addr_w,
    input  logic [31:0]         data_w,
    input  logic                ir_en,
    input  logic [IRQ_NUM-1:0]  ir_in,
    input  logic [31:0]         ret_addr,
    output logic                jump_en,
    output logic [31:0]         jump_addr,
    output logic [IRQ_NUM-1:0]  irq_ack
);

    localparam int unsigned STRIDE_SH = $clog2(VEC_STRIDE);
    localparam logic [1:0]  OP_MTC0   = 2'b10;
    localparam logic [1:0]  OP_ERET   = 2'b11;
    localparam logic [4:0]  REG_STATUS = 5'd12;
    localparam logic [4:0]  REG_CAUSE  = 5'd13;
    localparam logic [4:0]  REG_EPC    = 5'd14;
    localparam logic [4:0]  REG_EBASE  = 5'd15;

    typedef enum logic {S_IDLE, S_SERVICE} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_ie;
    logic [IRQ_NUM-1:0]   r_im;
    logic [IRQ_NUM-1:0]   r_ip;
    logic [4:0]           r_cause_idx;
    logic [31:0]          r_epc;
    logic [31:0]          r_ebase;
    logic [IRQ_NUM-1:0]   r_ir_prev;
    logic                 r_jump_en;
    logic [31:0]          r_jump_addr;
    logic [IRQ_NUM-1:0]   r_irq_ack;

    logic [IRQ_NUM-1:0]   w_ir_src;
    logic [IRQ_NUM-1:0]   w_edge;
    logic [IRQ_NUM-1:0]   w_pend;
    logic [IRQ_NUM-1:0]   w_onehot;
    logic [IRQ_NUM-1:0]   w_w1c;
    logic [IRQ_NUM-1:0]   w_take_clr;
    logic [4:0]           w_winner;
    logic                 w_take;
    logic                 w_wr_status;
    logic                 w_wr_cause;
    logic                 w_wr_epc;
    logic                 w_wr_ebase;
    logic [31:0]          w_epc_wr_val;
    logic                 w_jump_en_next;
    logic [31:0]          w_jump_addr_next;
    logic [IRQ_NUM-1:0]   w_ack_next;
    logic [31:0]          w_rd;

`ifdef IRQ_SYNC_EN
    logic [IRQ_NUM-1:0]   r_sync1;
    logic [IRQ_NUM-1:0]   r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ir_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ir_src = r_sync2;
`else
    assign w_ir_src = ir_in;
`endif

    assign w_edge      = w_ir_src & ~r_ir_prev;
    assign w_pend      = r_ip & r_im;
    assign w_wr_status = (oper == OP_MTC0) && (addr_w == REG_STATUS);
    assign w_wr_cause  = (oper == OP_MTC0) && (addr_w == REG_CAUSE);
    assign w_wr_epc    = (oper == OP_MTC0) && (addr_w == REG_EPC);
    assign w_wr_ebase  = (oper == OP_MTC0) && (addr_w == REG_EBASE);
    assign w_w1c       = w_wr_cause ? data_w[8 +: IRQ_NUM] : '0;
    assign w_epc_wr_val = w_wr_epc ? data_w : r_epc;
    assign w_onehot    = IRQ_NUM'(1) << w_winner;
    assign w_take_clr  = w_take ? w_onehot : '0;

    // Lowest pending-and-enabled index wins.
    always_comb begin
        w_winner = '0;
        for (int i = int'(IRQ_NUM) - 1; i >= 0; i--) begin
            if (w_pend[i]) w_winner = 5'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next     = r_state;
        w_take           = 1'b0;
        w_jump_en_next   = 1'b0;
        w_jump_addr_next = '0;
        w_ack_next       = '0;
        case (r_state)
            S_IDLE: begin
                if (r_ie && ir_en && (|w_pend) && (oper != OP_ERET)) begin
                    w_take           = 1'b1;
                    w_state_next     = S_SERVICE;
                    w_jump_en_next   = 1'b1;
                    w_jump_addr_next = r_ebase + (32'(w_winner) << STRIDE_SH);
                    w_ack_next       = w_onehot;
                end
            end
            S_SERVICE: begin
                if (oper == OP_ERET) begin
                    w_state_next     = S_IDLE;
                    w_jump_en_next   = 1'b1;
                    w_jump_addr_next = w_epc_wr_val;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Register file, pending capture (set beats clear) and redirect outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ie        <= 1'b0;
            r_im        <= '0;
            r_ip        <= '0;
            r_cause_idx <= '0;
            r_epc       <= '0;
            r_ebase     <= {VEC_BASE[31:2], 2'b00};
            r_ir_prev   <= '0;
            r_jump_en   <= 1'b0;
            r_jump_addr <= '0;
            r_irq_ack   <= '0;
        end else begin
            r_ir_prev   <= w_ir_src;
            r_ip        <= (r_ip & ~(w_w1c | w_take_clr)) | w_edge;
            r_epc       <= w_take ? ret_addr : w_epc_wr_val;
            r_jump_en   <= w_jump_en_next;
            r_jump_addr <= w_jump_addr_next;
            r_irq_ack   <= w_ack_next;
            if (w_wr_status) begin
                r_ie <= data_w[0];
                r_im <= data_w[8 +: IRQ_NUM];
            end
            if (w_take) r_cause_idx <= w_winner;
            if (w_wr_ebase) r_ebase <= {data_w[31:2], 2'b00};
        end
    end

    always_comb begin
        w_rd = '0;
        case (addr_r)
            REG_STATUS: begin
                w_rd[0]            = r_ie;
                w_rd[1]            = (r_state == S_SERVICE);
                w_rd[8 +: IRQ_NUM] = r_im;
            end
            REG_CAUSE: begin
                w_rd[8 +: IRQ_NUM] = r_ip;
                w_rd[6:2]          = r_cause_idx;
            end
            REG_EPC:   w_rd = r_epc;
            REG_EBASE: w_rd = r_ebase;
            default:   w_rd = '0;
        endcase
    end

    assign data_r    = w_rd;
    assign jump_en   = r_jump_en;
    assign jump_addr = r_jump_addr;
    assign irq_ack   = r_irq_ack;

endmodule

// File: tb/tb_cp0_vectored.sv
// Directed bench for cp0_vectored with a scoreboard of expected redirects.
`timescale 1ns/1ps
module tb_cp0_vectored;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  ack;
    } jump_t;

    logic        clk;
    logic        rst;
    logic [1:0]  oper;
    logic [4:0]  addr_r;
    logic [31:0] data_r;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        ir_en;
    logic [7:0]  ir_in;
    logic [31:0] ret_addr;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic [7:0]  irq_ack;

    int checks;
    int failures;
    jump_t sb[$];

    cp0_vectored #(
        .IRQ_NUM(8),
        .VEC_BASE(32'h0000_0100),
        .VEC_STRIDE(8)
    ) dut (
        .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r),
        .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ir_in(ir_in),
        .ret_addr(ret_addr), .jump_en(jump_en), .jump_addr(jump_addr), .irq_ack(irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Cycles from an ir_in edge until the pending bit is visible.
    task automatic edge_wait();
        cyc();
`ifdef IRQ_SYNC_EN
        cyc();
        cyc();
`endif
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr_r = a;
        #0.1;
        chk(tag, data_r, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        oper   = 2'b10;
        addr_w = a;
        data_w = d;
        cyc();
        oper   = 2'b00;
    endtask

    task automatic eret();
        oper = 2'b11;
        cyc();
        oper = 2'b00;
    endtask

    task automatic push(input logic [31:0] a, input logic [7:0] k);
        jump_t e;
        e.addr = a;
        e.ack  = k;
        sb.push_back(e);
    endtask

    // Every redirect pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && jump_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_jump", jump_addr, 32'hxxxx_xxxx);
            end else begin
                jump_t e;
                e = sb.pop_front();
                chk("sb_jump_addr", jump_addr, e.addr);
                chk("sb_irq_ack", 32'(irq_ack), 32'(e.ack));
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; oper = 2'b00; addr_r = '0; addr_w = '0; data_w = '0;
        ir_en = 1'b0; ir_in = '0; ret_addr = '0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // Reset state
        chk("rst_jump_en", 32'(jump_en), 32'd0);
        chk("rst_jump_addr", jump_addr, 32'd0);
        chk("rst_irq_ack", 32'(irq_ack), 32'd0);
        rd_chk("rst_status", 5'd12, 32'h0);
        rd_chk("rst_cause", 5'd13, 32'h0);
        rd_chk("rst_epc", 5'd14, 32'h0);
        rd_chk("rst_ebase", 5'd15, 32'h100);

        // Single source take
        mtc0(5'd12, 32'h0000_0301);
        rd_chk("t1_status", 5'd12, 32'h301);
        ir_en = 1'b1; ret_addr = 32'h40;
        ir_in = 8'h02;
        push(32'h108, 8'h02);
        edge_wait();
        rd_chk("t1_cause_ip", 5'd13, 32'h200);
        chk("t1_no_jump_yet", 32'(jump_en), 32'd0);
        cyc();
        chk("t1_jump_en", 32'(jump_en), 32'd1);
        chk("t1_jump_addr", jump_addr, 32'h108);
        chk("t1_irq_ack", 32'(irq_ack), 32'h02);
        cyc();
        ir_in = 8'h00;
        chk("t1_pulse_end", 32'(jump_en), 32'd0);
        rd_chk("t1_epc", 5'd14, 32'h40);
        rd_chk("t1_cause", 5'd13, 32'h4);
        rd_chk("t1_status_exl", 5'd12, 32'h303);
        push(32'h40, 8'h00);
        eret();
        chk("t1_eret_jump", 32'(jump_en), 32'd1);
        chk("t1_eret_addr", jump_addr, 32'h40);
        cyc();
        rd_chk("t1_status_idle", 5'd12, 32'h301);

        // Two simultaneous sources: priority and back-to-back take after ERET
        mtc0(5'd12, 32'h0000_FF01);
        ret_addr = 32'h80;
        ir_in = 8'h28;
        push(32'h118, 8'h08);
        edge_wait();
        cyc();
        chk("t2_jump_addr", jump_addr, 32'h118);
        chk("t2_irq_ack", 32'(irq_ack), 32'h08);
        ir_in = 8'h00;
        cyc();
        rd_chk("t2_cause", 5'd13, 32'h200C);
        ret_addr = 32'h84;
        push(32'h80, 8'h00);
        push(32'h128, 8'h20);
        eret();
        chk("t2_eret_addr", jump_addr, 32'h80);
        cyc();
        chk("t2_take5_addr", jump_addr, 32'h128);
        chk("t2_take5_ack", 32'(irq_ack), 32'h20);
        rd_chk("t2_epc", 5'd14, 32'h84);
        push(32'h84, 8'h00);
        eret();
        chk("t2_eret2_addr", jump_addr, 32'h84);
        cyc();

        // Pending during SERVICE is held until ERET and ir_en
        ret_addr = 32'h200;
        ir_in = 8'h01;
        push(32'h100, 8'h01);
        edge_wait();
        cyc();
        chk("t3_take0", 32'(jump_en), 32'd1);
        ir_in = 8'h04;
        edge_wait();
        cyc();
        chk("t3_blocked", 32'(jump_en), 32'd0);
        rd_chk("t3_cause", 5'd13, 32'h400);
        ir_en = 1'b0;
        push(32'h200, 8'h00);
        eret();
        chk("t3_eret_addr", jump_addr, 32'h200);
        cyc();
        chk("t3_no_take_a", 32'(jump_en), 32'd0);
        cyc();
        chk("t3_no_take_b", 32'(jump_en), 32'd0);
        ir_en = 1'b1;
        push(32'h110, 8'h04);
        cyc();
        chk("t3_take2_en", 32'(jump_en), 32'd1);
        chk("t3_take2_addr", jump_addr, 32'h110);
        push(32'h200, 8'h00);
        eret();
        cyc();
        ir_in = 8'h00;
        cyc();
        cyc();

        // Masked source pends, W1C clears, ERET in IDLE ignored
        mtc0(5'd12, 32'h0000_FB01);
        ir_in = 8'h04;
        cyc();
`ifdef IRQ_SYNC_EN
        rd_chk("t4_sync_t1", 5'd13, 32'h008);
        cyc();
        rd_chk("t4_sync_t2", 5'd13, 32'h008);
        cyc();
`endif
        rd_chk("t4_ip_masked", 5'd13, 32'h408);
        cyc();
        chk("t4_no_take", 32'(jump_en), 32'd0);
        mtc0(5'd13, 32'h0000_0400);
        rd_chk("t4_w1c", 5'd13, 32'h008);
        oper = 2'b11;
        cyc();
        oper = 2'b00;
        chk("t4_eret_idle_a", 32'(jump_en), 32'd0);
        cyc();
        chk("t4_eret_idle_b", 32'(jump_en), 32'd0);

        // EBASE alignment, then async reset while the take pulse is high
        mtc0(5'd15, 32'h0000_1003);
        rd_chk("t5_ebase", 5'd15, 32'h1000);
        ret_addr = 32'h300;
        ir_in = 8'h05;
        push(32'h1000, 8'h01);
        edge_wait();
        cyc();
        chk("t5_jump_addr", jump_addr, 32'h1000);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_jump_en", 32'(jump_en), 32'd0);
        chk("t5_rst_ack", 32'(irq_ack), 32'd0);
        chk("t5_rst_addr", jump_addr, 32'd0);
        rd_chk("t5_rst_status", 5'd12, 32'h0);
        rd_chk("t5_rst_cause", 5'd13, 32'h0);
        rd_chk("t5_rst_epc", 5'd14, 32'h0);
        rd_chk("t5_rst_ebase", 5'd15, 32'h100);
        ir_in = 8'h00;
        cyc();
        rst = 1'b0;
        cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
